// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller: TMS-steered 16-state FSM, state decodes, TDO enable, RTI cycle counter.
// Optional JTAG_TAP_TDOEN_NEGEDGE_EN retimes o_tdoEn onto the falling edge of TCK.
module jtag_tap_ctrl #(
  parameter int IDLE_CNT_W = 8
) (
  input  logic                  i_tclk,
  input  logic                  i_trst_n,
  input  logic                  i_tms,
  output logic [3:0]            o_state,
  output logic                  o_stateIsTestLogicReset,
  output logic                  o_stateIsRunTestIdle,
  output logic                  o_stateIsCaptureDr,
  output logic                  o_stateIsShiftDr,
  output logic                  o_stateIsUpdateDr,
  output logic                  o_stateIsCaptureIr,
  output logic                  o_stateIsShiftIr,
  output logic                  o_stateIsUpdateIr,
  output logic                  o_tdoEn,
  output logic [IDLE_CNT_W-1:0] o_idleCount
);

  localparam logic [3:0] ST_TLR   = 4'hF;
  localparam logic [3:0] ST_RTI   = 4'hC;
  localparam logic [3:0] ST_SELDR = 4'h7;
  localparam logic [3:0] ST_CAPDR = 4'h6;
  localparam logic [3:0] ST_SHDR  = 4'h2;
  localparam logic [3:0] ST_EX1DR = 4'h1;
  localparam logic [3:0] ST_PAUDR = 4'h3;
  localparam logic [3:0] ST_EX2DR = 4'h0;
  localparam logic [3:0] ST_UPDDR = 4'h5;
  localparam logic [3:0] ST_SELIR = 4'h4;
  localparam logic [3:0] ST_CAPIR = 4'hE;
  localparam logic [3:0] ST_SHIR  = 4'hA;
  localparam logic [3:0] ST_EX1IR = 4'h9;
  localparam logic [3:0] ST_PAUIR = 4'hB;
  localparam logic [3:0] ST_EX2IR = 4'h8;
  localparam logic [3:0] ST_UPDIR = 4'hD;

  localparam logic [IDLE_CNT_W-1:0] IDLE_MAX = '1;

  logic [3:0]            state_q, state_d;
  logic [IDLE_CNT_W-1:0] idle_q, idle_d;
  logic                  tdo_en_d;

  always_comb begin
    state_d = ST_TLR;
    case (state_q)
      ST_TLR:   state_d = i_tms ? ST_TLR   : ST_RTI;
      ST_RTI:   state_d = i_tms ? ST_SELDR : ST_RTI;
      ST_SELDR: state_d = i_tms ? ST_SELIR : ST_CAPDR;
      ST_CAPDR: state_d = i_tms ? ST_EX1DR : ST_SHDR;
      ST_SHDR:  state_d = i_tms ? ST_EX1DR : ST_SHDR;
      ST_EX1DR: state_d = i_tms ? ST_UPDDR : ST_PAUDR;
      ST_PAUDR: state_d = i_tms ? ST_EX2DR : ST_PAUDR;
      ST_EX2DR: state_d = i_tms ? ST_UPDDR : ST_SHDR;
      ST_UPDDR: state_d = i_tms ? ST_SELDR : ST_RTI;
      ST_SELIR: state_d = i_tms ? ST_TLR   : ST_CAPIR;
      ST_CAPIR: state_d = i_tms ? ST_EX1IR : ST_SHIR;
      ST_SHIR:  state_d = i_tms ? ST_EX1IR : ST_SHIR;
      ST_EX1IR: state_d = i_tms ? ST_UPDIR : ST_PAUIR;
      ST_PAUIR: state_d = i_tms ? ST_EX2IR : ST_PAUIR;
      ST_EX2IR: state_d = i_tms ? ST_UPDIR : ST_SHIR;
      ST_UPDIR: state_d = i_tms ? ST_SELDR : ST_RTI;
      default:  state_d = ST_TLR;
    endcase
  end

  // Counter only advances while staying in RTI, so it is zero on entry and clears on exit.
  always_comb begin
    idle_d = '0;
    if (state_q == ST_RTI && state_d == ST_RTI) begin
      idle_d = (idle_q == IDLE_MAX) ? idle_q : idle_q + IDLE_CNT_W'(1);
    end
  end

  always_ff @(posedge i_tclk or negedge i_trst_n) begin
    if (!i_trst_n) begin
      state_q <= ST_TLR;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      idle_q  <= idle_d;
    end
  end

  assign tdo_en_d = (state_q == ST_SHDR) || (state_q == ST_SHIR);

`ifdef JTAG_TAP_TDOEN_NEGEDGE_EN
  logic tdo_en_q;

  always_ff @(negedge i_tclk or negedge i_trst_n) begin
    if (!i_trst_n) begin
      tdo_en_q <= 1'b0;
    end else begin
      tdo_en_q <= tdo_en_d;
    end
  end

  assign o_tdoEn = tdo_en_q;
`else
  assign o_tdoEn = tdo_en_d;
`endif

  assign o_state                 = state_q;
  assign o_idleCount             = idle_q;
  assign o_stateIsTestLogicReset = (state_q == ST_TLR);
  assign o_stateIsRunTestIdle    = (state_q == ST_RTI);
  assign o_stateIsCaptureDr      = (state_q == ST_CAPDR);
  assign o_stateIsShiftDr        = (state_q == ST_SHDR);
  assign o_stateIsUpdateDr       = (state_q == ST_UPDDR);
  assign o_stateIsCaptureIr      = (state_q == ST_CAPIR);
  assign o_stateIsShiftIr        = (state_q == ST_SHIR);
  assign o_stateIsUpdateIr       = (state_q == ST_UPDIR);

endmodule
